// File: rtl/vga_timing_pkg.sv
// Shared constants and types for the 640x480@60 raster timing generator.
package vga_timing_pkg;

    // Coordinate width covers totals up to 1024.
    localparam int unsigned COORD_W = 10;

    // Default 640x480@60 horizontal timing, in pixels.
    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_H_FP     = 16;
    localparam int unsigned DEF_H_SYNC   = 96;
    localparam int unsigned DEF_H_BP     = 48;

    // Default vertical timing, in lines.
    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_V_FP     = 10;
    localparam int unsigned DEF_V_SYNC   = 2;
    localparam int unsigned DEF_V_BP     = 33;

    localparam int unsigned DEF_H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int unsigned DEF_V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

    localparam int unsigned FLAG_W = 3;

    typedef logic [COORD_W-1:0] coord_t;

    // Raw timing flags carried through the delay line.
    typedef struct packed {
        logic active;
        logic hs;
        logic vs;
    } timing_flags_t;

endpackage

// File: rtl/vga_timing_gen_sync_delay_line.sv
// Enabled shift register for the timing flags; depth 0 is a wire.
module sync_delay_line #(
    parameter int unsigned DEPTH = 1,
    parameter int unsigned WIDTH = 3
) (
    input  logic             in_clk,
    input  logic             in_reset_n,
    input  logic             in_enable,
    input  logic [WIDTH-1:0] in_data,
    output logic [WIDTH-1:0] out_data
);

    if (DEPTH == 0) begin : g_bypass
        logic unused_ctrl;
        assign unused_ctrl = ^{in_clk, in_reset_n, in_enable};
        assign out_data    = in_data;
    end else begin : g_pipe
        logic [WIDTH-1:0] stage_q [DEPTH];
        logic [WIDTH-1:0] stage_d [DEPTH];

        // Shift one stage per enabled cycle, otherwise hold.
        always_comb begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                stage_d[i] = stage_q[i];
            end
            if (in_enable) begin
                stage_d[0] = in_data;
                for (int unsigned i = 1; i < DEPTH; i++) begin
                    stage_d[i] = stage_q[i-1];
                end
            end
        end

        // Stage registers with synchronous clear.
        always_ff @(posedge in_clk) begin
            if (!in_reset_n) begin
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    stage_q[i] <= '0;
                end
            end else begin
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    stage_q[i] <= stage_d[i];
                end
            end
        end

        assign out_data = stage_q[DEPTH-1];
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Free-running raster timing generator (640x480@60 by default).
// Coordinates are undelayed; active/hsync/vsync pass through PIPE_DELAY stages.
// Optional: define VGA_FRAME_COUNTER_EN for a 16-bit completed-frame counter.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE         = DEF_H_ACTIVE,
    parameter int unsigned H_FP             = DEF_H_FP,
    parameter int unsigned H_SYNC           = DEF_H_SYNC,
    parameter int unsigned H_BP             = DEF_H_BP,
    parameter int unsigned V_ACTIVE         = DEF_V_ACTIVE,
    parameter int unsigned V_FP             = DEF_V_FP,
    parameter int unsigned V_SYNC           = DEF_V_SYNC,
    parameter int unsigned V_BP             = DEF_V_BP,
    parameter int unsigned SYNC_ACTIVE_HIGH = 0,
    parameter int unsigned PIPE_DELAY       = 1
) (
    input  logic               in_clk,
    input  logic               in_reset_n,
    input  logic               in_enable,
    output logic [COORD_W-1:0] out_pix_x,
    output logic [COORD_W-1:0] out_pix_y,
    output logic               out_active,
    output logic               out_hsync,
    output logic               out_vsync,
    output logic               out_line_start,
    output logic               out_frame_start,
    output logic [15:0]        out_frame_count
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    if (PIPE_DELAY > 4 || H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_param_check
        $error("vga_timing_gen: PIPE_DELAY must be 0..4 and totals must not exceed 1024");
    end

    localparam coord_t H_LAST   = coord_t'(H_TOTAL - 1);
    localparam coord_t V_LAST   = coord_t'(V_TOTAL - 1);
    localparam coord_t H_ACT_C  = coord_t'(H_ACTIVE);
    localparam coord_t V_ACT_C  = coord_t'(V_ACTIVE);
    localparam coord_t HS_FIRST = coord_t'(H_ACTIVE + H_FP);
    localparam coord_t HS_LAST  = coord_t'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam coord_t VS_FIRST = coord_t'(V_ACTIVE + V_FP);
    localparam coord_t VS_LAST  = coord_t'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic   SYNC_HI  = (SYNC_ACTIVE_HIGH != 0);

    coord_t        x_q, x_d, y_q, y_d;
    logic          frame_wrap;
    timing_flags_t raw_flags;
    timing_flags_t dly_flags;

    // Next raster position; wraps at the end of each line and frame.
    always_comb begin
        x_d        = x_q;
        y_d        = y_q;
        frame_wrap = 1'b0;
        if (in_enable) begin
            if (x_q == H_LAST) begin
                x_d = '0;
                if (y_q == V_LAST) begin
                    y_d        = '0;
                    frame_wrap = 1'b1;
                end else begin
                    y_d = y_q + coord_t'(1);
                end
            end else begin
                x_d = x_q + coord_t'(1);
            end
        end
    end

    // Raster counters.
    always_ff @(posedge in_clk) begin
        if (!in_reset_n) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    // Undelayed timing decode from the current position.
    always_comb begin
        raw_flags.active = (x_q < H_ACT_C) && (y_q < V_ACT_C);
        raw_flags.hs     = (x_q >= HS_FIRST) && (x_q <= HS_LAST);
        raw_flags.vs     = (y_q >= VS_FIRST) && (y_q <= VS_LAST);
    end

    sync_delay_line #(
        .DEPTH (PIPE_DELAY),
        .WIDTH (FLAG_W)
    ) u_sync_delay_line (
        .in_clk     (in_clk),
        .in_reset_n (in_reset_n),
        .in_enable  (in_enable),
        .in_data    (raw_flags),
        .out_data   (dly_flags)
    );

    // Polarity is applied after the delay so a cleared line reads as deasserted.
    assign out_active = dly_flags.active;
    assign out_hsync  = dly_flags.hs ^ ~SYNC_HI;
    assign out_vsync  = dly_flags.vs ^ ~SYNC_HI;

    // Strobes are held low while reset is asserted so they read 0 during reset.
    assign out_line_start  = (x_q == '0) && in_enable && in_reset_n;
    assign out_frame_start = out_line_start && (y_q == '0);

    assign out_pix_x = x_q;
    assign out_pix_y = y_q;

`ifdef VGA_FRAME_COUNTER_EN
    logic [15:0] frame_count_q, frame_count_d;

    // Count completed frames, wrapping at 16 bits.
    always_comb begin
        frame_count_d = frame_count_q;
        if (frame_wrap) begin
            frame_count_d = frame_count_q + 16'd1;
        end
    end

    // Frame counter register.
    always_ff @(posedge in_clk) begin
        if (!in_reset_n) begin
            frame_count_q <= '0;
        end else begin
            frame_count_q <= frame_count_d;
        end
    end

    assign out_frame_count = frame_count_q;
`else
    logic unused_frame_wrap;
    assign unused_frame_wrap = frame_wrap;
    assign out_frame_count   = '0;
`endif

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Free-running 640x480@60 raster timing generator.
- Sits directly upstream of the hex-display overlay and the other pixel-producing stages. It drives their pixel x/y inputs and produces the VGA hsync, vsync and active-video outputs.
- Sync and active outputs are delayed by a programmable number of pixel cycles, so they line up with registered pixel producers downstream.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, horizontal sync width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vertical sync lines
- V_BP, 33, vertical back porch
- SYNC_ACTIVE_HIGH, 0, 0 = syncs asserted low
- PIPE_DELAY, 1, pixel-cycle delay (0..4) applied to out_hsync, out_vsync and out_active only

Ports:
- in_clk  input  1  system clock
- in_reset_n  input  1  synchronous, active-low reset
- in_enable  input  1  pixel-clock enable; counters advance only when high
- out_pix_x  output  10  horizontal counter, 0..H_TOTAL-1
- out_pix_y  output  10  vertical counter, 0..V_TOTAL-1
- out_active  output  1  delayed active-video flag
- out_hsync  output  1  delayed horizontal sync, polarity per SYNC_ACTIVE_HIGH
- out_vsync  output  1  delayed vertical sync
- out_line_start  output  1  high for one in_clk cycle when x==0 and in_enable=1
- out_frame_start  output  1  high for one in_clk cycle when x==0, y==0 and in_enable=1
- out_frame_count  output  16  completed-frame count (optional feature; otherwise 0)

Behaviour:
- Clocking and reset:
  - One clock; reset is synchronous and active-low.
  - Reset has priority over in_enable.
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- Reset values:
  - out_pix_x = 0, out_pix_y = 0.
  - Delay-line contents cleared: out_active = 0, syncs deasserted (1 when SYNC_ACTIVE_HIGH=0).
  - out_line_start = 0, out_frame_start = 0, out_frame_count = 0.
  - Reset asserted mid-frame takes effect at the next edge regardless of counter state.
- Counters, updated on edges where in_enable=1:
  - x increments; at x == H_TOTAL-1, x wraps to 0 and y increments.
  - At x == H_TOTAL-1 and y == V_TOTAL-1, both wrap to 0.
  - in_enable=0 holds all registers, including the delay line.
- Coordinates are output undelayed. They count through blanking; x reaches 799 and y reaches 524, so downstream windowing on the high bits stays valid.
- Raw (undelayed) timing decode from the current x, y:
  - active_raw = (x < H_ACTIVE) && (y < V_ACTIVE)
  - hs_raw = x in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], i.e. 656..751
  - vs_raw = y in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1], i.e. 490..491
- Delay line:
  - The raw flags pass through PIPE_DELAY enabled stages; PIPE_DELAY=0 is a combinational pass-through from the decode.
  - Sync polarity is applied after the delay.
- Start strobes:
  - out_line_start and out_frame_start are decoded from the registered counters ANDed with in_enable.
  - Each is therefore exactly one in_clk cycle wide, even when in_enable is gated.
- Elaboration check: PIPE_DELAY outside 0..4, or H_TOTAL/V_TOTAL > 1024, is an elaboration error.

Optional Feature:
- VGA_FRAME_COUNTER_EN defined:
  - out_frame_count is a 16-bit register that increments on the enabled edge where x and y both wrap to 0.
  - It wraps from 0xFFFF to 0 and is cleared by reset.
  - Intended as a latch trigger and debug source for the hex overlay.
- Undefined: the port remains present and is tied to 16'h0000, with no register.

Decomposition:
- Package vga_timing_pkg holds:
  - default 640x480 constants (H_ACTIVE, H_FP, H_SYNC, H_BP, V_*);
  - derived H_TOTAL and V_TOTAL;
  - the coordinate width localparam (10).
- One sub-module, sync_delay_line:
  - parameterised depth and width (3 bits: active, hs, vs), with enable and synchronous active-low clear;
  - depth 0 is a pass-through.

Test Plan:
- Reset release with in_enable=1 → first cycle x=0, y=0, out_frame_start=1, out_line_start=1, hsync=1, vsync=1, active=0 (PIPE_DELAY=1). Next cycle: active=1.
- Run to x=799, y=0 → next edge gives x=0, y=1, line_start=1, frame_start=0. At x=656, out_hsync goes low one cycle later and stays low through x=752 (96 cycles).
- Run a full frame → vsync low for exactly 2×800 enabled cycles, starting one cycle after (x=0, y=490). (x=799, y=524) wraps to (0,0) with frame_start=1.
- in_enable toggling 1/0 → counters advance every other clock, strobes never exceed one clock, delay line holds while disabled. PIPE_DELAY=0 → hsync toggles in the same cycle as x=656.
- Assert in_reset_n=0 at (x=300, y=200) for one cycle → next cycle all outputs equal reset values. Counting resumes from (0,0).
- VGA_FRAME_COUNTER_EN defined: 3 full frames → out_frame_count=3; preload near 0xFFFF and observe wrap to 0. Undefined: out_frame_count constant 0.
